// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: forwards UART commands when idle and replays the move store as
// vertical/horizontal cmd pairs, handshaking with cmd_proc after every command.
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES  = 24,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned TIMEOUT    = 0,
  parameter int unsigned TO_W       = 24,
  parameter bit          FANFARE_EN = 1'b1,
  parameter logic [7:0]  RESP_DONE  = 8'hA5,
  parameter logic [7:0]  RESP_BUSY  = 8'h5A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic             abort,
  input  logic [2:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_done,
  output logic             tour_err
);

  typedef enum logic [2:0] {StIdle, StVertForm, StVertWait, StHoriForm, StHoriWait} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_MOVES - 1);
  localparam logic [TO_W-1:0]  ToLimit = TO_W'(TIMEOUT);
  localparam logic [3:0]       VertOp  = 4'h2;
  localparam logic [3:0]       HoriOp  = FANFARE_EN ? 4'h3 : 4'h2;
  localparam logic [7:0]       HdN = 8'h00;
  localparam logic [7:0]       HdS = 8'h7F;
  localparam logic [7:0]       HdW = 8'h3F;
  localparam logic [7:0]       HdE = 8'hBF;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       v_head, h_head;
  logic [3:0]       v_sq, h_sq;
  logic             in_wait, timed_out;

  always_comb begin
    v_head = HdN;
    v_sq   = 4'd0;
    h_head = HdW;
    h_sq   = 4'd0;
    unique case (move)
      3'd0: begin v_head = HdN; v_sq = 4'd2; h_head = HdW; h_sq = 4'd1; end
      3'd1: begin v_head = HdN; v_sq = 4'd2; h_head = HdE; h_sq = 4'd1; end
      3'd2: begin v_head = HdN; v_sq = 4'd1; h_head = HdW; h_sq = 4'd2; end
      3'd3: begin v_head = HdS; v_sq = 4'd1; h_head = HdW; h_sq = 4'd2; end
      3'd4: begin v_head = HdS; v_sq = 4'd2; h_head = HdW; h_sq = 4'd1; end
      3'd5: begin v_head = HdS; v_sq = 4'd2; h_head = HdE; h_sq = 4'd1; end
      3'd6: begin v_head = HdS; v_sq = 4'd1; h_head = HdE; h_sq = 4'd2; end
      3'd7: begin v_head = HdN; v_sq = 4'd1; h_head = HdE; h_sq = 4'd2; end
      default: ;
    endcase
  end

  assign in_wait   = (state_q == StVertWait) || (state_q == StHoriWait);
  // send_resp on the expiry cycle takes precedence over the timeout
  assign timed_out = (TIMEOUT != 0) && in_wait && (cnt_q == ToLimit) && !send_resp;
  // Counter is zero outside WAIT, so every WAIT entry starts counting from 0
  assign cnt_d     = in_wait ? cnt_q + TO_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q != StIdle && abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_tour && !abort) begin
            idx_d   = '0;
            state_d = StVertForm;
          end
        end
        StVertForm: if (clr_cmd_rdy) state_d = StVertWait;
        StVertWait: begin
          if (send_resp) begin
            state_d = StHoriForm;
          end else if (timed_out) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StHoriForm: if (clr_cmd_rdy) state_d = StHoriWait;
        StHoriWait: begin
          if (send_resp) begin
            if (idx_q == LastIdx) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = StVertForm;
            end
          end else if (timed_out) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cmd     = 16'h0000;
    cmd_rdy = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
      end
      StVertForm: begin
        cmd     = {VertOp, v_head, v_sq};
        cmd_rdy = 1'b1;
      end
      StHoriForm: begin
        cmd     = {HoriOp, h_head, h_sq};
        cmd_rdy = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    resp = RESP_BUSY;
    if (state_q == StIdle) begin
      resp = RESP_DONE;
    end else if ((state_q == StHoriForm || state_q == StHoriWait) && idx_q == LastIdx) begin
      resp = RESP_DONE;
    end
  end

  assign mv_indx   = idx_q;
  assign tour_busy = (state_q != StIdle);
  assign tour_done = done_q;
  assign tour_err  = err_q;

endmodule
